// File: rtl/sine_pwm_sequencer.sv
// Sine LUT sequencer and PWM carrier: steps the LUT address on a prescaled strobe,
// converts each signed sample to an unsigned duty and applies it only at carrier wrap.
module sine_pwm_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int LUT_DEPTH  = 102,
    parameter int ADDR_W     = 7,
    parameter int SAMPLE_DIV = 3163
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic [ADDR_W-1:0]   lut_addr,
    output logic                lut_rd,
    input  logic [PWM_BITS-1:0] lut_data,
    output logic                pwm_out,
    output logic                sample_tick,
    output logic                cycle_done,
    output logic                busy
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MID_DUTY    = PWM_BITS'(1 << (PWM_BITS - 1));
    localparam logic [PWM_BITS-1:0] CARRIER_MAX = {PWM_BITS{1'b1}};
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0]   ADDR_LAST   = ADDR_W'(LUT_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] carrier_q, carrier_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                capture_q, capture_d;
    logic [PWM_BITS-1:0] pending_q, pending_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic [PWM_BITS-1:0] conv_duty;
    logic                carrier_wrap;

    // Flipping the sign bit maps two's-complement -min..+max onto 0..2**N-1.
    assign conv_duty    = lut_data ^ MID_DUTY;
    assign carrier_wrap = (carrier_q == CARRIER_MAX);

    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        div_d     = div_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        capture_d = 1'b0;
        pending_d = pending_q;
        active_d  = active_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        pwm_d     = 1'b0;

        if (state_q != ST_IDLE) begin
            carrier_d = carrier_q + 1'b1;
            capture_d = rd_q;
            if (capture_q) begin
                pending_d = conv_duty;
            end
            // A sample landing on the wrap cycle goes straight to the new period.
            if (carrier_wrap) begin
                active_d = capture_q ? conv_duty : pending_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                carrier_d = '0;
                div_d     = '0;
                addr_d    = '0;
                if (enable) begin
                    state_d   = ST_RUN;
                    pending_d = MID_DUTY;
                    active_d  = MID_DUTY;
                    rd_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                    rd_d   = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        addr_d = '0;
                        done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (carrier_wrap) begin
                    state_d   = ST_IDLE;
                    carrier_d = '0;
                    div_d     = '0;
                    addr_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Computed from next-state values so pwm_out lines up with the carrier it belongs to.
        if (state_d != ST_IDLE) begin
            pwm_d = (carrier_d < active_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            carrier_q <= '0;
            div_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            capture_q <= 1'b0;
            pending_q <= '0;
            active_q  <= '0;
            pwm_q     <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            div_q     <= div_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            capture_q <= capture_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign lut_addr    = addr_q;
    assign lut_rd      = rd_q;
    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign cycle_done  = done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sine_pwm_sequencer.sv
// Directed bench for sine_pwm_sequencer with a 4-bit carrier, 4-entry LUT and divide-by-8 strobe.
module tb_sine_pwm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] lut_addr;
    logic       lut_rd;
    logic [3:0] lut_data = 4'h0;
    logic       pwm_out;
    logic       sample_tick;
    logic       cycle_done;
    logic       busy;

    logic [3:0] rom [4];
    int n_checks = 0;
    int n_pass   = 0;
    int r        = 0;

    sine_pwm_sequencer #(
        .PWM_BITS  (4),
        .LUT_DEPTH (4),
        .ADDR_W    (2),
        .SAMPLE_DIV(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lut_addr   (lut_addr),
        .lut_rd     (lut_rd),
        .lut_data   (lut_data),
        .pwm_out    (pwm_out),
        .sample_tick(sample_tick),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (lut_rd) lut_data <= rom[lut_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, r, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        r++;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // From IDLE: raise enable; returns sampled in the first RUN cycle (r = 0).
    task automatic start_run();
        enable = 1'b1;
        step();
        r = 0;
    endtask

    // Checks one carrier period cycle by cycle, starting at carrier = 0.
    task automatic check_period(input string tag, input int duty);
        for (int i = 0; i < 16; i++) begin
            check(tag, pwm_out, (i < duty) ? 1 : 0);
            step();
        end
    endtask

    task automatic load_std_rom();
        rom[0] = 4'h8;   // -8
        rom[1] = 4'h0;   //  0
        rom[2] = 4'h7;   // +7
        rom[3] = 4'hF;   // -1
    endtask

    initial begin
        logic [3:0] conv_val [3];
        int         conv_exp [3];
        int         duty_tab [4];

        // Reset with enable already high
        load_std_rom();
        step();
        step();
        check("rst_pwm", pwm_out, 0);
        check("rst_addr", lut_addr, 0);
        check("rst_rd", lut_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", cycle_done, 0);
        check("rst_tick", sample_tick, 0);
        $display("reset phase complete");
        enable = 1'b0;
        rst_n  = 1'b1;
        step();

        // Conversion: constant ROM contents, second period shows converted duty
        conv_val[0] = 4'h8; conv_exp[0] = 0;
        conv_val[1] = 4'h7; conv_exp[1] = 15;
        conv_val[2] = 4'h0; conv_exp[2] = 8;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4; a++) rom[a] = conv_val[k];
            start_run();
            check("conv_first_addr", lut_addr, 0);
            check("conv_first_rd", lut_rd, 1);
            check_period("conv_mid_period", 8);
            check_period("conv_period", conv_exp[k]);
            $display("conversion sample %0d -> duty %0d phase complete", conv_val[k], conv_exp[k]);
            do_reset();
        end

        // Sequencing, wrap and glitch-free duty changes at carrier = 0
        load_std_rom();
        duty_tab[0] = 8; duty_tab[1] = 8; duty_tab[2] = 7; duty_tab[3] = 8;
        start_run();
        for (int c = 0; c < 64; c++) begin
            check("seq_tick", sample_tick, ((c % 8 == 0) && (c != 0)) ? 1 : 0);
            check("seq_rd", lut_rd, (c % 8 == 0) ? 1 : 0);
            check("seq_addr", lut_addr, (c / 8) % 4);
            check("seq_done", cycle_done, (c == 32) ? 1 : 0);
            check("seq_busy", busy, 1);
            check("seq_pwm", pwm_out, ((c % 16) < duty_tab[c / 16]) ? 1 : 0);
            step();
        end
        $display("sequencing phase complete");
        do_reset();

        // Disable at carrier = 5 of the second period; drain to wrap
        start_run();
        for (int c = 0; c < 21; c++) step();
        check("drain_pre_busy", busy, 1);
        enable = 1'b0;
        for (int c = 22; c < 32; c++) begin
            step();
            check("drain_busy", busy, 1);
            check("drain_rd", lut_rd, 0);
            check("drain_tick", sample_tick, 0);
            check("drain_addr", lut_addr, 2);
            check("drain_pwm", pwm_out, ((c % 16) < 8) ? 1 : 0);
        end
        for (int c = 32; c < 36; c++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_pwm", pwm_out, 0);
            check("idle_rd", lut_rd, 0);
            check("idle_addr", lut_addr, 0);
        end
        start_run();
        check("restart_addr", lut_addr, 0);
        check("restart_rd", lut_rd, 1);
        check("restart_busy", busy, 1);
        $display("drain phase complete");

        // Asynchronous reset between clock edges in the middle of RUN
        for (int c = 0; c < 16; c++) step();
        check("pre_arst_addr", lut_addr, 2);
        check("pre_arst_tick", sample_tick, 1);
        check("pre_arst_pwm", pwm_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", pwm_out, 0);
        check("arst_busy", busy, 0);
        check("arst_rd", lut_rd, 0);
        check("arst_addr", lut_addr, 0);
        check("arst_tick", sample_tick, 0);
        #1;
        rst_n = 1'b1;
        step();
        r = 0;
        check("rerun_addr", lut_addr, 0);
        check("rerun_rd", lut_rd, 1);
        check("rerun_busy", busy, 1);
        check_period("rerun_period", 8);
        $display("async reset phase complete");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
